// File: rtl/riscv_pkg.sv
// Shared types for the RISC-V core: bus word, memory op encoding and LSU states.
// Helper functions classify memory ops by direction and alignment.
package riscv_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        MEM_NONE, LB, LH, LW, LBU, LHU, SB, SH, SW
    } mem_op_t;

    typedef enum logic [1:0] {
        LSU_IDLE, LSU_REQ, LSU_WAIT
    } lsu_state_t;

    function automatic logic is_store(mem_op_t op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

    function automatic logic is_misaligned(mem_op_t op, logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (op)
            LH, LHU, SH: bad = off[0];
            LW, SW:      bad = (off != 2'b00);
            default:     bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte enables / replicated data,
// and load lane extraction with sign or zero extension.
module lsu_align
    import riscv_pkg::*;
(
    input  mem_op_t     st_op,
    input  logic [1:0]  st_off,
    input  word_t       st_data,
    output logic [3:0]  be,
    output word_t       lane_data,
    input  mem_op_t     ld_op,
    input  logic [1:0]  ld_off,
    input  word_t       rdata,
    output word_t       ld_data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        be        = 4'b0000;
        lane_data = '0;
        unique case (st_op)
            SB: begin
                be        = 4'b0001 << st_off;
                lane_data = {4{st_data[7:0]}};
            end
            SH: begin
                be        = st_off[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{st_data[15:0]}};
            end
            SW: begin
                be        = 4'b1111;
                lane_data = st_data;
            end
            LB, LBU: be = 4'b0001 << st_off;
            LH, LHU: be = st_off[1] ? 4'b1100 : 4'b0011;
            LW:      be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    always_comb begin
        lane_b  = rdata[{ld_off, 3'b000} +: 8];
        lane_h  = ld_off[1] ? rdata[31:16] : rdata[15:0];
        ld_data = rdata;
        unique case (ld_op)
            LB:      ld_data = {{24{lane_b[7]}}, lane_b};
            LBU:     ld_data = {24'h0, lane_b};
            LH:      ld_data = {{16{lane_h[15]}}, lane_h};
            LHU:     ld_data = {16'h0, lane_h};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts ALU results, runs the dmem req/gnt/rvalid handshake
// and emits one registered writeback beat per instruction.
module lsu
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  mem_op_t     ex_mem_op,
    input  word_t       ex_addr,
    input  word_t       ex_wdata,
    input  logic [4:0]  ex_rd,
    output logic        dmem_req,
    output logic        dmem_we,
    output word_t       dmem_addr,
    output logic [3:0]  dmem_be,
    output word_t       dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  word_t       dmem_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output word_t       wb_data,
    output logic        misalign,
    output logic        bus_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);

    lsu_state_t    state, state_d;
    mem_op_t       op_q;
    logic [1:0]    off_q;
    logic [CW-1:0] cnt;
    logic          accept, bad, mem_acc, timeout;
    logic [3:0]    st_be;
    word_t         st_lanes, ld_ext;

    assign ex_ready = (state == LSU_IDLE);
    assign accept   = ex_valid & ex_ready;
    assign bad      = is_misaligned(ex_mem_op, ex_addr[1:0]);
    assign mem_acc  = accept & (ex_mem_op != MEM_NONE) & ~bad;
    assign timeout  = (cnt == CW'(TIMEOUT_CYCLES - 1));

    lsu_align u_align (
        .st_op     (ex_mem_op),
        .st_off    (ex_addr[1:0]),
        .st_data   (ex_wdata),
        .be        (st_be),
        .lane_data (st_lanes),
        .ld_op     (op_q),
        .ld_off    (off_q),
        .rdata     (dmem_rdata),
        .ld_data   (ld_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LSU_IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            LSU_IDLE: if (mem_acc) state_d = LSU_REQ;
            LSU_REQ: begin
                if (dmem_gnt)
                    state_d = is_store(op_q) ? LSU_IDLE : LSU_WAIT;
            end
            LSU_WAIT: if (dmem_rvalid || timeout) state_d = LSU_IDLE;
            default: state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= MEM_NONE;
            off_q      <= 2'b00;
            cnt        <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= 4'b0000;
            dmem_wdata <= '0;
            wb_valid   <= 1'b0;
            wb_we      <= 1'b0;
            wb_rd      <= 5'd0;
            wb_data    <= '0;
            misalign   <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            misalign <= 1'b0;
            bus_err  <= 1'b0;
            if (accept) begin
                op_q  <= ex_mem_op;
                off_q <= ex_addr[1:0];
                wb_rd <= ex_rd;
                if (ex_mem_op == MEM_NONE) begin
                    wb_valid <= 1'b1;
                    wb_we    <= (ex_rd != 5'd0);
                    wb_data  <= ex_addr;
                end else if (bad) begin
                    wb_valid <= 1'b1;
                    misalign <= 1'b1;
                    wb_data  <= ex_addr;
                end else begin
                    dmem_req   <= 1'b1;
                    dmem_we    <= is_store(ex_mem_op);
                    dmem_addr  <= {ex_addr[31:2], 2'b00};
                    dmem_be    <= st_be;
                    dmem_wdata <= st_lanes;
                end
            end
            if (state == LSU_REQ && dmem_gnt) begin
                dmem_req <= 1'b0;
                cnt      <= '0;
                if (is_store(op_q)) wb_valid <= 1'b1;
            end
            // rvalid on the final WAIT cycle takes priority over the timeout
            if (state == LSU_WAIT) begin
                if (dmem_rvalid) begin
                    wb_valid <= 1'b1;
                    wb_we    <= (wb_rd != 5'd0);
                    wb_data  <= ld_ext;
                end else if (timeout) begin
                    wb_valid <= 1'b1;
                    bus_err  <= 1'b1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases then random ops against
// an arithmetic reference model of lane steering, extension and timing.
module tb_lsu;
    import riscv_pkg::*;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ex_valid = 1'b0;
    logic       ex_ready;
    mem_op_t    ex_mem_op = MEM_NONE;
    word_t      ex_addr = '0;
    word_t      ex_wdata = '0;
    logic [4:0] ex_rd = '0;
    logic       dmem_req, dmem_we;
    word_t      dmem_addr, dmem_wdata;
    logic [3:0] dmem_be;
    logic       dmem_gnt = 1'b0;
    logic       dmem_rvalid = 1'b0;
    word_t      dmem_rdata = '0;
    logic       wb_valid, wb_we, misalign, bus_err;
    logic [4:0] wb_rd;
    word_t      wb_data;

    int passes = 0;
    int total  = 0;

    always #5 clk = ~clk;

    lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_mem_op(ex_mem_op), .ex_addr(ex_addr),
        .ex_wdata(ex_wdata), .ex_rd(ex_rd),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .misalign(misalign), .bus_err(bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference: access size in bytes drives alignment, enables,
    // replication and extension through plain arithmetic.
    function automatic void model(input mem_op_t op, input word_t addr,
                                  input word_t wd, input word_t rdata,
                                  output bit mis, output logic [3:0] be,
                                  output word_t lanes, output word_t ld);
        int     sz;
        int     off;
        longint mask, v;
        bit     sgn;
        sz  = (op == LH || op == LHU || op == SH) ? 2 :
              (op == LW || op == SW) ? 4 : 1;
        sgn = (op == LB || op == LH);
        off = int'(addr & 32'd3);
        mis = (op != MEM_NONE) && ((addr % sz) != 0);
        mask = (64'd1 << (8 * sz)) - 1;
        be = 4'(((1 << sz) - 1) << off);
        v = longint'(wd) & mask;
        lanes = word_t'(v * ((sz == 1) ? 64'h01010101 :
                             (sz == 2) ? 64'h00010001 : 64'd1));
        v = (longint'(rdata) >> (8 * off)) & mask;
        if (sgn && v >= (mask + 1) / 2) v = v - (mask + 1);
        ld = word_t'(v);
    endfunction

    task automatic run_op(input mem_op_t op, input word_t addr,
                          input word_t wd, input logic [4:0] rd,
                          input int gdly, input int rdly,
                          input word_t rdata);
        bit         mis, st, tmo;
        logic [3:0] be;
        word_t      lanes, ld;
        int         fin;
        model(op, addr, wd, rdata, mis, be, lanes, ld);
        st = (op == SB || op == SH || op == SW);
        chk("ex_ready", ex_ready, 1);
        ex_valid = 1'b1; ex_mem_op = op; ex_addr = addr;
        ex_wdata = wd; ex_rd = rd;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        ex_mem_op = mem_op_t'(4'($urandom_range(0, 8)));
        ex_addr = $urandom;
        if (op == MEM_NONE || mis) begin
            chk("no_req", dmem_req, 0);
            chk("wb_valid", wb_valid, 1);
            chk("misalign", misalign, mis);
            chk("wb_we", wb_we, (!mis && rd != 0));
            chk("wb_rd", wb_rd, rd);
            if (!mis) chk("wb_data", wb_data, addr);
            return;
        end
        chk("req", dmem_req, 1);
        chk("we", dmem_we, st);
        chk("daddr", dmem_addr, addr & 32'hFFFF_FFFC);
        chk("early_wb", wb_valid, 0);
        if (st) begin
            chk("be", dmem_be, be);
            chk("wdata", dmem_wdata, lanes);
        end
        for (int i = 0; i < gdly; i++) begin
            @(posedge clk); #1;
            chk("req_hold", dmem_req, 1);
            chk("addr_hold", dmem_addr, addr & 32'hFFFF_FFFC);
        end
        dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        chk("req_drop", dmem_req, 0);
        if (st) begin
            chk("st_wb_valid", wb_valid, 1);
            chk("st_wb_we", wb_we, 0);
            chk("st_err", {misalign, bus_err}, 0);
            chk("st_wb_rd", wb_rd, rd);
            return;
        end
        tmo = (rdly + 1 > TO);
        fin = tmo ? TO : rdly + 1;
        for (int c = 1; c <= fin; c++) begin
            dmem_rvalid = (c == rdly + 1);
            dmem_rdata  = dmem_rvalid ? rdata : $urandom;
            @(posedge clk); #1;
            dmem_rvalid = 1'b0;
            chk("wb_timing", wb_valid, (c == fin));
        end
        chk("bus_err", bus_err, tmo);
        chk("ld_misalign", misalign, 0);
        chk("ld_wb_we", wb_we, (!tmo && rd != 0));
        chk("ld_wb_rd", wb_rd, rd);
        if (!tmo) chk("ld_data", wb_data, ld);
    endtask

    initial begin
        #1;
        chk("rst_ready", ex_ready, 1);
        chk("rst_req", {dmem_req, dmem_we, dmem_be}, 0);
        chk("rst_daddr", dmem_addr, 0);
        chk("rst_dwdata", dmem_wdata, 0);
        chk("rst_wb", {wb_valid, wb_we, wb_rd, misalign, bus_err}, 0);
        chk("rst_wbdata", wb_data, 0);
        #13 rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(MEM_NONE, 32'h42, 32'h0, 5'd5, 0, 0, 0);
        chk("none_noreq", dmem_req, 0);
        run_op(SB, 32'h103, 32'hAB, 5'd3, 2, 0, 0);
        run_op(LB, 32'h102, 32'h0, 5'd4, 0, 0, 32'h0080_0000);
        chk("lb_neg", wb_data, 32'hFFFF_FF80);
        run_op(LBU, 32'h102, 32'h0, 5'd4, 1, 1, 32'h0080_0000);
        chk("lbu_pos", wb_data, 32'h0000_0080);
        run_op(LW, 32'h202, 32'h0, 5'd8, 0, 0, 0);
        run_op(SH, 32'h201, 32'h1234, 5'd9, 0, 0, 0);
        run_op(LW, 32'h400, 32'h0, 5'd6, 1, TO + 5, 0);
        run_op(LW, 32'h404, 32'h0, 5'd6, 0, TO - 1, 32'h1234_5678);

        // reset while waiting for load data
        ex_valid = 1'b1; ex_mem_op = LW; ex_addr = 32'h300; ex_rd = 5'd7;
        @(posedge clk); #1;
        ex_valid = 1'b0; dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        @(posedge clk); #1;
        chk("wait_busy", ex_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", ex_ready, 1);
        chk("arst_daddr", dmem_addr, 0);
        chk("arst_wbdata", wb_data, 0);
        chk("arst_ctl", {dmem_req, dmem_we, wb_valid, wb_we, wb_rd}, 0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(LW, 32'h500, 32'h0, 5'd0, 0, 2, 32'hDEAD_BEEF);

        for (int n = 0; n < 80; n++) begin
            mem_op_t    op;
            logic [4:0] rd;
            int         rdly;
            op   = mem_op_t'(4'($urandom_range(0, 8)));
            rd   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            rdly = ($urandom_range(0, 7) == 0) ? TO + 1 : $urandom_range(0, 3);
            run_op(op, $urandom, $urandom, rd, $urandom_range(0, 3),
                   rdly, $urandom);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
